// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Responder end of the instruction-fetch interface. Fetch issues pipelined read
// requests with a valid/ready handshake. Each accepted request reads the
// word-organised instruction store and travels through a LATENCY-stage tag
// pipeline. Responses come back in request order through a response FIFO that
// absorbs fetch backpressure.
//
// The store is loaded at run time through the prog_* write port.
//
// Optional feature (compile-time macro IMEM_RESPONDER_ERR_EN):
//   defined     - misaligned or out-of-window request addresses return
//                 rsp_err=1 with a NOP word, and out-of-window program writes
//                 are dropped.
//   not defined - rsp_err is tied 0 and every address aliases modulo
//                 DEPTH_WORDS.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   req_valid  fetch presents a request
//   req_ready  responder can accept a request
//   req_addr   byte address of requested instruction
//   rsp_valid  response available
//   rsp_ready  fetch consumes response
//   rsp_addr   address the response belongs to
//   rsp_data   instruction word
//   rsp_err    access error (0 unless IMEM_RESPONDER_ERR_EN)
//   prog_we    program-load write strobe
//   prog_addr  program-load byte address
//   prog_data  program-load word
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int                AWIDTH      = 32,
    parameter int                DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h0100_0000),
    parameter int                DEPTH_WORDS = 1024,
    parameter int                LATENCY     = 2,
    parameter int                QDEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [AWIDTH-1:0] rsp_addr,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              prog_we,
    input  logic [AWIDTH-1:0] prog_addr,
    input  logic [DWIDTH-1:0] prog_data
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [DWIDTH-1:0] NOP_WORD = DWIDTH'(32'h0000_0013);

    // ---------------- address decode ----------------
    logic [AWIDTH-1:0] req_off;
    logic [AWIDTH-1:0] prog_off;
    logic [IW-1:0]     req_idx;
    logic [IW-1:0]     prog_idx;
    logic              req_bad;
    logic              prog_ok;
    logic              unused_bits;

    assign req_off  = req_addr - BASE_ADDR;
    assign prog_off = prog_addr - BASE_ADDR;
    assign req_idx  = req_off[IW+1:2];
    assign prog_idx = prog_off[IW+1:2];

`ifdef IMEM_RESPONDER_ERR_EN
    // Offset is unsigned, so addresses below BASE_ADDR wrap to a large offset
    // and fall outside the window as well.
    assign req_bad = (req_addr[1:0] != 2'b00) || (req_off[AWIDTH-1:IW+2] != '0);
    assign prog_ok = (prog_off[AWIDTH-1:IW+2] == '0);
`else
    assign req_bad = 1'b0;
    assign prog_ok = 1'b1;
`endif

    assign unused_bits = ^{req_off, prog_off};

    // ---------------- handshake / outstanding count ----------------
    logic          ready_en_reg;
    logic [CW-1:0] out_cnt_reg;
    logic          accept;
    logic          pop;

    // ready_en_reg keeps req_ready low while reset is held.
    assign req_ready = ready_en_reg && (out_cnt_reg < CW'(QDEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_reg <= 1'b0;
            out_cnt_reg  <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (accept && !pop)
                out_cnt_reg <= out_cnt_reg + CW'(1);
            else if (!accept && pop)
                out_cnt_reg <= out_cnt_reg - CW'(1);
        end
    end

    // ---------------- instruction store ----------------
    logic [DWIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (prog_we && prog_ok)
            mem[prog_idx] <= prog_data;
    end

    // ---------------- tag pipeline ----------------
    // Stage 0 is the registered store read; a same-edge program write
    // therefore yields the old word.
    logic              pipe_valid_reg [LATENCY];
    logic [AWIDTH-1:0] pipe_addr_reg  [LATENCY];
    logic [DWIDTH-1:0] pipe_data_reg  [LATENCY];
    logic              pipe_err_reg   [LATENCY];

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst)
                        pipe_valid_reg[0] <= 1'b0;
                    else
                        pipe_valid_reg[0] <= accept;
                    if (accept) begin
                        pipe_addr_reg[0] <= req_addr;
                        pipe_err_reg[0]  <= req_bad;
                        if (!req_bad)
                            pipe_data_reg[0] <= mem[req_idx];
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clk) begin
                    if (rst)
                        pipe_valid_reg[gi] <= 1'b0;
                    else
                        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                    pipe_addr_reg[gi] <= pipe_addr_reg[gi-1];
                    pipe_data_reg[gi] <= pipe_data_reg[gi-1];
                    pipe_err_reg[gi]  <= pipe_err_reg[gi-1];
                end
            end
        end
    endgenerate

    logic              tail_valid;
    logic [AWIDTH-1:0] tail_addr;
    logic [DWIDTH-1:0] tail_data;
    logic              tail_err;

    // Error responses never read the store; the NOP replaces whatever
    // stale word the stage-0 register still holds.
    assign tail_valid = pipe_valid_reg[LATENCY-1];
    assign tail_addr  = pipe_addr_reg[LATENCY-1];
    assign tail_err   = pipe_err_reg[LATENCY-1];
    assign tail_data  = tail_err ? NOP_WORD : pipe_data_reg[LATENCY-1];

    // ---------------- response FIFO ----------------
    // When the FIFO is empty the pipeline tail is presented directly, so a
    // response is visible LATENCY cycles after accept. An unpopped tail is
    // then written into the FIFO and remains the head, keeping rsp_* stable.
    logic [AWIDTH-1:0] fifo_addr_reg [QDEPTH];
    logic [DWIDTH-1:0] fifo_data_reg [QDEPTH];
    logic              fifo_err_reg  [QDEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     fifo_cnt_reg;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    assign fifo_empty = (fifo_cnt_reg == '0);
    assign rsp_valid  = !fifo_empty || tail_valid;
    assign fifo_pop   = pop && !fifo_empty;
    assign fifo_push  = tail_valid && !(fifo_empty && pop);

    always_comb begin
        rsp_addr = '0;
        rsp_data = '0;
        rsp_err  = 1'b0;
        if (!fifo_empty) begin
            rsp_addr = fifo_addr_reg[rd_ptr_reg];
            rsp_data = fifo_data_reg[rd_ptr_reg];
            rsp_err  = fifo_err_reg[rd_ptr_reg];
        end else if (tail_valid) begin
            rsp_addr = tail_addr;
            rsp_data = tail_data;
            rsp_err  = tail_err;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_addr_reg[wr_ptr_reg] <= tail_addr;
            fifo_data_reg[wr_ptr_reg] <= tail_data;
            fifo_err_reg[wr_ptr_reg]  <= tail_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (fifo_push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (fifo_pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (fifo_push && !fifo_pop)
                fifo_cnt_reg <= fifo_cnt_reg + CW'(1);
            else if (!fifo_push && fifo_pop)
                fifo_cnt_reg <= fifo_cnt_reg - CW'(1);
        end
    end

endmodule
